trolley_system_motor_drive: RTL and testbench
=============================================

// Module: trolley_system_motor_drive
// PURPOSE
//   H-bridge PWM driver for one trolley drive motor. Consumes the 3-bit command held by the motor_l
//   PIO out_port and turns it into a PWM enable plus direction pins. Duty ramps between speeds,
//   and every direction reversal is forced through ramp-down to zero plus a dead time.
//   Sits between the Avalon PIO and the board-level motor bridge pins.
// PARAMETERS
//   PWM_PERIOD   1000   PWM period in clk cycles; must be < 2**CNT_W
//   CNT_W        10     width of PWM counter and duty register
//   RAMP_STEP    10     duty change applied per PWM period while ramping
//   DEAD_CYCLES  50000  clk cycles in DEAD before the new direction is applied (>=1)
// PORTS
//   clk      in   1      system clock, single domain
//   reset    in   1      synchronous, active-high reset
//   cmd      in   3      from motor_l out_port: [2]=direction (1=reverse), [1:0]=speed code
//   pwm_out  out  1      PWM enable to bridge
//   in1      out  1      bridge input A
//   in2      out  1      bridge input B
//   duty     out  CNT_W  current applied duty, in clk cycles high per period
//   busy     out  1      high in RAMP_DN or DEAD, or while duty != target
// BEHAVIOUR
//   - Reset (clk edge with reset=1): state=IDLE, cnt=0, duty=0, dir_q=0, dead_cnt=0.
//     Reset forces pwm_out=0, in1=0, in2=0, busy=0. Reset mid-operation aborts ramp/dead immediately.
//   - cmd is registered once (cmd_q). All decisions use cmd_q, so there is 1 cycle of input latency.
//   - Speed target: code 0 -> 0, 1 -> PWM_PERIOD/4, 2 -> PWM_PERIOD/2, 3 -> PWM_PERIOD.
//     Division is integer, floor.
//   - PWM counter: cnt counts 0..PWM_PERIOD-1, then wraps to 0. The boundary is the cycle where cnt==PWM_PERIOD-1.
//   - pwm_out = registered (cnt < duty). duty==PWM_PERIOD gives constant high; duty==0 gives constant low.
//   - duty changes only at a boundary, so no pulse is ever truncated:
//     - duty < tgt: duty = min(duty+RAMP_STEP, tgt)
//     - duty > tgt: duty = max(duty-RAMP_STEP, tgt)
//     - compute at CNT_W+1 bits; never over- or underflows.
//   - Effective target tgt is 0 in IDLE, RAMP_DN and DEAD, and the cmd_q speed target in RUN.
//   - FSM:
//     - IDLE: in1=in2=0. If speed code != 0: dir_q <= cmd_q[2], go to RUN.
//     - RUN: in1=~dir_q, in2=dir_q.
//       - If cmd_q[2] != dir_q: go to RAMP_DN.
//       - Else if speed code == 0 and duty == 0: go to IDLE.
//     - RAMP_DN: pins keep dir_q and duty ramps to 0. When duty==0: dead_cnt <= DEAD_CYCLES-1, go to DEAD.
//     - DEAD: pwm_out=0 and bridge pins per CONFIGURATION; dead_cnt decrements.
//       At dead_cnt==0: dir_q <= cmd_q[2]; go to RUN if speed code != 0, else IDLE.
//   - Simultaneous or repeated events:
//     - Direction toggled back during RAMP_DN: ramp-down still completes, then DEAD runs.
//       dir_q takes the latest cmd_q[2] at DEAD exit.
//     - Speed change during a ramp: retargets at the next boundary.
//     - Speed 0 while in RAMP_DN/DEAD: resolved at DEAD exit (-> IDLE).
//   - in1 and in2 are never both 1 unless the BRAKE option is active in DEAD.
// CONFIGURATION
//   TROLLEY_MOTOR_BRAKE_EN defined:     in DEAD, in1=in2=1 (active brake, low-side short).
//   TROLLEY_MOTOR_BRAKE_EN not defined: in DEAD, in1=in2=0 (coast).
//   All other states are identical in both builds.
// TESTING  (bench params: PWM_PERIOD=8, CNT_W=4, RAMP_STEP=2, DEAD_CYCLES=4)
//   1 Reset: hold reset 3 cycles with cmd=3'b011 -> pwm_out=in1=in2=0, duty=0, busy=0 throughout.
//   2 Ramp-up: cmd=3'b011 from IDLE -> in1=1, in2=0.
//     duty = 2, 4, 6, 8 at successive boundaries; busy drops when duty=8; pwm_out then constant 1.
//   3 Ramp-down: cmd 3'b010 (duty=4), then 3'b000.
//     -> duty 2, then 0 at the next two boundaries; state IDLE; in1=in2=0.
//   4 Reversal: RUN fwd at duty=4, cmd=3'b110.
//     -> duty 2, 0; then exactly 4 DEAD cycles with pwm_out=0.
//     -> then in1=0, in2=1; duty ramps 2, 4.
//   5 Toggle-back: reversal as in 4, cmd returns to 3'b010 during DEAD.
//     -> DEAD completes, in1=1, in2=0, duty ramps to 4.
//   6 BRAKE_EN build, scenario 4: in1=in2=1 exactly during the 4 DEAD cycles.
//     Non-BRAKE build: in1=in2=0 during DEAD. Assertion: in1&in2 never 1 outside DEAD.

Source files
------------

// File: rtl/trolley_system_motor_drive.sv
// H-bridge PWM driver for one trolley motor: ramped duty, forced ramp-down plus dead time on reversal.
// Build option: define TROLLEY_MOTOR_BRAKE_EN to short both bridge inputs high during DEAD (active brake).
module trolley_system_motor_drive #(
  parameter int PWM_PERIOD  = 1000,
  parameter int CNT_W       = 10,
  parameter int RAMP_STEP   = 10,
  parameter int DEAD_CYCLES = 50000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       cmd,
  output logic             pwm_out,
  output logic             in1,
  output logic             in2,
  output logic [CNT_W-1:0] duty,
  output logic             busy
);

  localparam int               DEAD_W    = $clog2(DEAD_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(PWM_PERIOD - 1);
  localparam logic [CNT_W-1:0] STEP      = CNT_W'(RAMP_STEP);
  localparam logic [CNT_W:0]   STEP_X    = (CNT_W + 1)'(RAMP_STEP);
  localparam logic [DEAD_W-1:0] DEAD_INIT = DEAD_W'(DEAD_CYCLES - 1);

`ifdef TROLLEY_MOTOR_BRAKE_EN
  localparam logic DEAD_PIN = 1'b1;
`else
  localparam logic DEAD_PIN = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, RUN, RAMP_DN, DEAD} state_t;

  state_t            r_state;
  logic [2:0]        r_cmdQ;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  r_duty;
  logic              r_dirQ;
  logic [DEAD_W-1:0] r_deadCnt;
  logic              r_pwm;
  logic              r_in1;
  logic              r_in2;

  logic              w_boundary;
  logic              w_speedNz;
  logic [CNT_W-1:0]  w_tgt;
  logic [CNT_W-1:0]  w_nextDuty;
  logic [CNT_W:0]    w_dutyX;
  logic [CNT_W:0]    w_tgtX;

  function automatic logic [CNT_W-1:0] speedTarget(input logic [1:0] code);
    case (code)
      2'd0:    speedTarget = '0;
      2'd1:    speedTarget = CNT_W'(PWM_PERIOD / 4);
      2'd2:    speedTarget = CNT_W'(PWM_PERIOD / 2);
      default: speedTarget = CNT_W'(PWM_PERIOD);
    endcase
  endfunction

  // Duty only moves at the period boundary and is clamped to the target, one extra bit of headroom.
  always_comb begin
    w_boundary = (r_cnt == CNT_MAX);
    w_speedNz  = (r_cmdQ[1:0] != 2'd0);
    w_tgt      = (r_state == RUN) ? speedTarget(r_cmdQ[1:0]) : '0;
    w_dutyX    = {1'b0, r_duty};
    w_tgtX     = {1'b0, w_tgt};
    w_nextDuty = r_duty;
    if (w_boundary) begin
      if (w_dutyX < w_tgtX)
        w_nextDuty = (w_dutyX + STEP_X >= w_tgtX) ? w_tgt : r_duty + STEP;
      else if (w_dutyX > w_tgtX)
        w_nextDuty = (w_dutyX <= w_tgtX + STEP_X) ? w_tgt : r_duty - STEP;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_cmdQ    <= '0;
      r_cnt     <= '0;
      r_duty    <= '0;
      r_dirQ    <= 1'b0;
      r_deadCnt <= '0;
      r_pwm     <= 1'b0;
      r_in1     <= 1'b0;
      r_in2     <= 1'b0;
    end else begin
      r_cmdQ <= cmd;
      r_cnt  <= w_boundary ? '0 : r_cnt + CNT_W'(1);
      r_duty <= w_nextDuty;
      r_pwm  <= (r_state != DEAD) && (r_cnt < r_duty);
      // Bridge pins are set on the transition so they always line up with the state register.
      case (r_state)
        IDLE: begin
          if (w_speedNz) begin
            r_dirQ  <= r_cmdQ[2];
            r_in1   <= ~r_cmdQ[2];
            r_in2   <= r_cmdQ[2];
            r_state <= RUN;
          end
        end
        RUN: begin
          if (r_cmdQ[2] != r_dirQ) begin
            r_state <= RAMP_DN;
          end else if (!w_speedNz && r_duty == '0) begin
            r_in1   <= 1'b0;
            r_in2   <= 1'b0;
            r_state <= IDLE;
          end
        end
        RAMP_DN: begin
          if (r_duty == '0) begin
            r_deadCnt <= DEAD_INIT;
            r_in1     <= DEAD_PIN;
            r_in2     <= DEAD_PIN;
            r_state   <= DEAD;
          end
        end
        DEAD: begin
          if (r_deadCnt == '0) begin
            r_dirQ <= r_cmdQ[2];
            if (w_speedNz) begin
              r_in1   <= ~r_cmdQ[2];
              r_in2   <= r_cmdQ[2];
              r_state <= RUN;
            end else begin
              r_in1   <= 1'b0;
              r_in2   <= 1'b0;
              r_state <= IDLE;
            end
          end else begin
            r_deadCnt <= r_deadCnt - DEAD_W'(1);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign pwm_out = r_pwm;
  assign in1     = r_in1;
  assign in2     = r_in2;
  assign duty    = r_duty;
  assign busy    = (r_state == RAMP_DN) || (r_state == DEAD) || (r_duty != w_tgt);

endmodule

// File: tb/tb_trolley_system_motor_drive.sv
// Directed self-checking bench for trolley_system_motor_drive (PWM_PERIOD=8, CNT_W=4, RAMP_STEP=2, DEAD_CYCLES=4).
// Expectations follow TROLLEY_MOTOR_BRAKE_EN so the same bench covers both builds.
module tb_trolley_system_motor_drive;

  localparam int PWM_PERIOD  = 8;
  localparam int CNT_W       = 4;
  localparam int RAMP_STEP   = 2;
  localparam int DEAD_CYCLES = 4;

`ifdef TROLLEY_MOTOR_BRAKE_EN
  localparam logic DEAD_PIN      = 1'b1;
  localparam int   BOTH_HIGH_EXP = 8;
`else
  localparam logic DEAD_PIN      = 1'b0;
  localparam int   BOTH_HIGH_EXP = 0;
`endif

  logic             clk = 1'b0;
  logic             reset;
  logic [2:0]       cmd;
  logic             pwm_out;
  logic             in1;
  logic             in2;
  logic [CNT_W-1:0] duty;
  logic             busy;

  int checkCount = 0;
  int errorCount = 0;
  int bothHigh   = 0;
  int highCount;

  trolley_system_motor_drive #(
    .PWM_PERIOD (PWM_PERIOD),
    .CNT_W      (CNT_W),
    .RAMP_STEP  (RAMP_STEP),
    .DEAD_CYCLES(DEAD_CYCLES)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .cmd    (cmd),
    .pwm_out(pwm_out),
    .in1    (in1),
    .in2    (in2),
    .duty   (duty),
    .busy   (busy)
  );

  always #5 clk = ~clk;

  // Both bridge inputs high is only legal in DEAD of the brake build.
  always @(negedge clk) begin
    if (in1 === 1'b1 && in2 === 1'b1) bothHigh++;
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    if (obs !== exp) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic [2:0] c);
    reset = r;
    cmd   = c;
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic waitDuty(input string tag, input int exp, input int budget);
    for (int i = 0; i < budget && duty !== CNT_W'(exp); i++) @(negedge clk);
    checkOutput(tag, 32'(duty), 32'(exp));
  endtask

  task automatic countHigh(output int n);
    n = 0;
    repeat (PWM_PERIOD) begin
      @(negedge clk);
      if (pwm_out === 1'b1) n++;
    end
  endtask

  initial begin
    applyStimulus(1'b1, 3'b011);
    for (int i = 0; i < 3; i++) begin
      tick(1);
      checkOutput("rst_pwm", 32'(pwm_out), 0);
      checkOutput("rst_in1", 32'(in1), 0);
      checkOutput("rst_in2", 32'(in2), 0);
      checkOutput("rst_duty", 32'(duty), 0);
      checkOutput("rst_busy", 32'(busy), 0);
    end

    // Ramp-up to full speed forward.
    applyStimulus(1'b0, 3'b011);
    for (int i = 0; i < 20 && in1 !== 1'b1; i++) tick(1);
    checkOutput("up_in1", 32'(in1), 1);
    checkOutput("up_in2", 32'(in2), 0);
    waitDuty("up_2", 2, 20);
    tick(7);
    checkOutput("up_hold2", 32'(duty), 2);
    checkOutput("up_busy", 32'(busy), 1);
    tick(1);
    checkOutput("up_4", 32'(duty), 4);
    tick(8);
    checkOutput("up_6", 32'(duty), 6);
    tick(8);
    checkOutput("up_8", 32'(duty), 8);
    checkOutput("up_busy_done", 32'(busy), 0);
    tick(1);
    for (int i = 0; i < PWM_PERIOD; i++) begin
      checkOutput("full_pwm", 32'(pwm_out), 1);
      tick(1);
    end

    // Slow to half speed, then stop.
    applyStimulus(1'b0, 3'b010);
    waitDuty("dn_4", 4, 40);
    countHigh(highCount);
    checkOutput("half_high_cycles", 32'(highCount), 4);
    applyStimulus(1'b0, 3'b000);
    waitDuty("dn_2", 2, 40);
    tick(8);
    checkOutput("dn_0", 32'(duty), 0);
    tick(2);
    checkOutput("idle_in1", 32'(in1), 0);
    checkOutput("idle_in2", 32'(in2), 0);
    checkOutput("idle_busy", 32'(busy), 0);

    // Reversal forward -> reverse with dead time.
    applyStimulus(1'b0, 3'b010);
    waitDuty("rv_up4", 4, 60);
    checkOutput("rv_fwd_in1", 32'(in1), 1);
    applyStimulus(1'b0, 3'b110);
    waitDuty("rv_2", 2, 40);
    tick(8);
    checkOutput("rv_0", 32'(duty), 0);
    checkOutput("rv_rampdn_in1", 32'(in1), 1);
    checkOutput("rv_rampdn_in2", 32'(in2), 0);
    checkOutput("rv_rampdn_busy", 32'(busy), 1);
    for (int k = 0; k < DEAD_CYCLES; k++) begin
      tick(1);
      checkOutput("dead_in1", 32'(in1), 32'(DEAD_PIN));
      checkOutput("dead_in2", 32'(in2), 32'(DEAD_PIN));
      checkOutput("dead_pwm", 32'(pwm_out), 0);
      checkOutput("dead_busy", 32'(busy), 1);
    end
    tick(1);
    checkOutput("rv_in1", 32'(in1), 0);
    checkOutput("rv_in2", 32'(in2), 1);
    waitDuty("rv_ramp2", 2, 20);
    tick(8);
    checkOutput("rv_ramp4", 32'(duty), 4);
    checkOutput("rv_busy_done", 32'(busy), 0);

    // Reset while running reverse aborts everything at once.
    applyStimulus(1'b1, 3'b010);
    tick(1);
    checkOutput("mid_rst_duty", 32'(duty), 0);
    checkOutput("mid_rst_in1", 32'(in1), 0);
    checkOutput("mid_rst_in2", 32'(in2), 0);
    checkOutput("mid_rst_pwm", 32'(pwm_out), 0);
    checkOutput("mid_rst_busy", 32'(busy), 0);

    // Reversal with direction toggled back during DEAD.
    applyStimulus(1'b0, 3'b010);
    waitDuty("tb_up4", 4, 60);
    checkOutput("tb_fwd_in1", 32'(in1), 1);
    applyStimulus(1'b0, 3'b110);
    waitDuty("tb_0", 0, 60);
    tick(1);
    applyStimulus(1'b0, 3'b010);
    tick(3);
    checkOutput("tb_dead_in1", 32'(in1), 32'(DEAD_PIN));
    checkOutput("tb_dead_in2", 32'(in2), 32'(DEAD_PIN));
    tick(1);
    checkOutput("tb_in1", 32'(in1), 1);
    checkOutput("tb_in2", 32'(in2), 0);
    waitDuty("tb_ramp2", 2, 20);
    tick(8);
    checkOutput("tb_ramp4", 32'(duty), 4);

    checkOutput("both_high_cycles", 32'(bothHigh), 32'(BOTH_HIGH_EXP));

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
